// File: rtl/character_counter_digit.sv
// One digit of a ripple-chained character counter: steps through a programmable
// list of up to 127 characters and passes an advance request upward on wrap.
module character_counter_digit (
  input  logic          i_count,
  input  logic          i_reset,
  input  logic          i_carry_in,
  output logic          o_carry_out,
  input  logic [7:0]    i_prg_numchars,
  input  logic [1015:0] i_prg_charlist,
  input  logic          i_enable,
  input  logic          i_program,
  output logic [7:0]    o_char
);

  logic [1015:0] r_list;
  logic [7:0]    r_numchars;
  logic [6:0]    r_index;

  logic [6:0]    w_last_idx;
  logic          w_wrap;
  logic          w_advance;
  logic [7:0]    w_byte;

  // Effective length clamped to 1..127, expressed as the last valid index.
  always_comb begin
    w_last_idx = 7'd0;
    if (r_numchars == 8'd0) begin
      w_last_idx = 7'd0;
    end else if (r_numchars > 8'd127) begin
      w_last_idx = 7'd126;
    end else begin
      w_last_idx = r_numchars[6:0] - 7'd1;
    end
  end

  // ">=" also wraps an index stranded beyond a shortened list.
  assign w_wrap      = (r_index >= w_last_idx);
  assign w_advance   = i_enable & i_carry_in;
  assign o_carry_out = w_advance & w_wrap;

  always_ff @(posedge i_count) begin
    if (i_reset) begin
      r_list     <= '0;
      r_numchars <= 8'd1;
      r_index    <= 7'd0;
    end else if (i_program) begin
      r_list     <= i_prg_charlist;
      r_numchars <= i_prg_numchars;
      r_index    <= 7'd0;
    end else if (w_advance) begin
      r_index    <= w_wrap ? 7'd0 : r_index + 7'd1;
    end
  end

  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < 127; k++) begin
      if (r_index == 7'(k)) begin
        w_byte = r_list[8*k +: 8];
      end
    end
  end

  assign o_char = i_enable ? w_byte : 8'h00;

endmodule

// File: tb/tb_character_counter_digit.sv
// Two chained digits checked every cycle against a list/modulo model, plus
// directed sequences with literal expectations.
module tb_character_counter_digit;

  logic          clk = 1'b0;
  logic          rst, prog_lo, prog_hi, en_lo, en_hi, cin_lo;
  logic [7:0]    numchars;
  logic [1015:0] plist;
  logic          co_lo, co_hi;
  logic [7:0]    ch_lo, ch_hi;

  always #5 clk = ~clk;

  character_counter_digit u_lo (
    .i_count(clk), .i_reset(rst), .i_carry_in(cin_lo), .o_carry_out(co_lo),
    .i_prg_numchars(numchars), .i_prg_charlist(plist),
    .i_enable(en_lo), .i_program(prog_lo), .o_char(ch_lo)
  );

  character_counter_digit u_hi (
    .i_count(clk), .i_reset(rst), .i_carry_in(co_lo), .o_carry_out(co_hi),
    .i_prg_numchars(numchars), .i_prg_charlist(plist),
    .i_enable(en_hi), .i_program(prog_hi), .o_char(ch_hi)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte list, a raw length and an integer position per digit.
  byte unsigned m_list[2][127];
  int           m_raw[2];
  int           m_idx[2];
  logic         m_c_lo;
  logic         n_c_lo;

  function automatic int eff_n(int raw);
    if (raw == 0) return 1;
    if (raw > 127) return 127;
    return raw;
  endfunction

  function automatic logic m_carry(int i, logic en, logic cin);
    return en && cin && (m_idx[i] == eff_n(m_raw[i]) - 1);
  endfunction

  function automatic logic [7:0] m_char(int i, logic en);
    return en ? m_list[i][m_idx[i]] : 8'h00;
  endfunction

  task automatic m_update(int i, logic r, logic p, logic en, logic cin);
    if (r) begin
      for (int k = 0; k < 127; k++) m_list[i][k] = 8'h00;
      m_raw[i] = 1;
      m_idx[i] = 0;
    end else if (p) begin
      for (int k = 0; k < 127; k++) m_list[i][k] = plist[8*k +: 8];
      m_raw[i] = int'(numchars);
      m_idx[i] = 0;
    end else if (en && cin) begin
      m_idx[i] = (m_idx[i] + 1) % eff_n(m_raw[i]);
    end
  endtask

  always @(posedge clk) begin
    m_c_lo = m_carry(0, en_lo, cin_lo);
    m_update(0, rst, prog_lo, en_lo, cin_lo);
    m_update(1, rst, prog_hi, en_hi, m_c_lo);
  end

  always @(negedge clk) begin
    if (check_en) begin
      n_c_lo = m_carry(0, en_lo, cin_lo);
      chk("mdl_char_lo", ch_lo, m_char(0, en_lo));
      chk("mdl_co_lo", {7'b0, co_lo}, {7'b0, n_c_lo});
      chk("mdl_char_hi", ch_hi, m_char(1, en_hi));
      chk("mdl_co_hi", {7'b0, co_hi}, {7'b0, m_carry(1, en_hi, n_c_lo)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_list(string s);
    plist = '0;
    for (int k = 0; k < s.len(); k++) plist[8*k +: 8] = s[k];
  endtask

  initial begin
    string seq;
    rst = 1'b1; prog_lo = 1'b0; prog_hi = 1'b0;
    en_lo = 1'b1; en_hi = 1'b0; cin_lo = 1'b1;
    numchars = 8'd0; plist = '0;

    tick();
    chk("rst_char_lo", ch_lo, 8'h00);
    chk("rst_co_lo", {7'b0, co_lo}, 8'd1);
    chk("rst_char_hi", ch_hi, 8'h00);
    chk("rst_co_hi", {7'b0, co_hi}, 8'd0);
    check_en = 1'b1;
    rst = 1'b0;

    // "abc" sequence; junk on prg bus while program is low must be ignored
    set_list("abc"); numchars = 8'd3; prog_lo = 1'b1;
    tick();
    prog_lo = 1'b0;
    seq = "abcab";
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("abc_char", ch_lo, seq[i]);
      chk("abc_co", {7'b0, co_lo}, {7'b0, seq[i] == 8'h63});
      if (i == 1) begin set_list("xyz"); numchars = 8'd9; end
    end

    // disabled digit holds position and outputs nothing
    en_lo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dis_char", ch_lo, 8'h00);
      chk("dis_co", {7'b0, co_lo}, 8'd0);
    end
    en_lo = 1'b1;
    #1;
    chk("reen_char", ch_lo, 8'h62);
    tick();
    chk("reen_adv_char", ch_lo, 8'h63);
    chk("reen_adv_co", {7'b0, co_lo}, 8'd1);

    // reset and program on the same edge: reset wins
    rst = 1'b1; prog_lo = 1'b1; set_list("xyz"); numchars = 8'd3;
    tick();
    chk("rstprog_char", ch_lo, 8'h00);
    chk("rstprog_co", {7'b0, co_lo}, 8'd1);
    rst = 1'b0; prog_lo = 1'b0;
    tick();
    chk("n1_char", ch_lo, 8'h00);
    chk("n1_co", {7'b0, co_lo}, 8'd1);
    cin_lo = 1'b0;
    #1;
    chk("n1_co_nocin", {7'b0, co_lo}, 8'd0);
    cin_lo = 1'b1;

    // reprogram to a shorter list while at index 2
    set_list("abc"); numchars = 8'd3; prog_lo = 1'b1;
    tick();
    prog_lo = 1'b0;
    tick(); tick();
    chk("pre_reprog_char", ch_lo, 8'h63);
    set_list("pq"); numchars = 8'd2; prog_lo = 1'b1;
    tick();
    prog_lo = 1'b0;
    chk("reprog_char", ch_lo, 8'h70);
    chk("reprog_co", {7'b0, co_lo}, 8'd0);
    tick();
    chk("reprog_q", ch_lo, 8'h71);
    chk("reprog_q_co", {7'b0, co_lo}, 8'd1);
    tick();
    chk("reprog_wrap", ch_lo, 8'h70);

    // numchars = 0 acts as a single-entry list
    set_list("k"); numchars = 8'd0; prog_lo = 1'b1;
    tick();
    prog_lo = 1'b0;
    chk("n0_char", ch_lo, 8'h6b);
    chk("n0_co", {7'b0, co_lo}, 8'd1);
    repeat (3) tick();
    chk("n0_hold", ch_lo, 8'h6b);
    cin_lo = 1'b0;
    #1;
    chk("n0_co_nocin", {7'b0, co_lo}, 8'd0);
    cin_lo = 1'b1;

    // numchars = 200 acts as 127; byte k holds k+1
    plist = '0;
    for (int k = 0; k < 127; k++) plist[8*k +: 8] = 8'(k + 1);
    numchars = 8'd200; prog_lo = 1'b1;
    tick();
    prog_lo = 1'b0;
    chk("n127_first", ch_lo, 8'd1);
    repeat (126) tick();
    chk("n127_last", ch_lo, 8'd127);
    chk("n127_last_co", {7'b0, co_lo}, 8'd1);
    tick();
    chk("n127_wrap", ch_lo, 8'd1);
    chk("n127_wrap_co", {7'b0, co_lo}, 8'd0);

    // two-digit chain over "01"
    en_hi = 1'b1;
    set_list("01"); numchars = 8'd2; prog_lo = 1'b1; prog_hi = 1'b1;
    tick();
    prog_lo = 1'b0; prog_hi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      chk("chain_hi", ch_hi, ((i / 2) % 2 == 1) ? 8'h31 : 8'h30);
      chk("chain_lo", ch_lo, (i % 2 == 1) ? 8'h31 : 8'h30);
      chk("chain_co_hi", {7'b0, co_hi}, {7'b0, (i % 4) == 3});
    end
    en_hi = 1'b0;
    tick(); tick();

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
